// File: rtl/lcd_msg_scheduler_pkg.sv
// rtl/lcd_msg_scheduler_pkg.sv - LCD command codes, line geometry and scheduler state encoding
package lcd_msg_scheduler_pkg;

  localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
  localparam int         LCD_CHARS     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ADDR,
    S_CHAR,
    S_DONE
  } state_t;

  // char0 sits in the most significant byte of the 128-bit line image
  function automatic logic [7:0] lcd_char_at(input logic [127:0] text, input logic [3:0] idx);
    return text[8*(LCD_CHARS-1-int'(idx)) +: 8];
  endfunction

  function automatic logic [7:0] lcd_line_cmd(input logic line);
    return line ? LCD_CMD_LINE2 : LCD_CMD_LINE1;
  endfunction

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// rtl/lcd_msg_scheduler_if.sv - byte handshake between the scheduler and the LCD byte writer
interface lcd_msg_scheduler_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_byte;
  logic       wr_ready;
  logic       init_done;

  modport master (
    output wr_valid, wr_rs, wr_byte,
    input  wr_ready, init_done
  );

  modport slave (
    input  wr_valid, wr_rs, wr_byte,
    output wr_ready, init_done
  );
endinterface

// File: rtl/lcd_msg_scheduler_arbiter.sv
// rtl/lcd_msg_scheduler_arbiter.sv - requester selection; LCD_SCHED_RR_EN selects round-robin,
// otherwise fixed priority with the lowest index winning
module lcd_req_arbiter
  import lcd_msg_scheduler_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_grant,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  assign o_valid = |i_req;

`ifdef LCD_SCHED_RR_EN
  logic [IDX_W-1:0] r_ptr;

  // Scan from the far end so the requester closest to the pointer is assigned last
  always_comb begin
    o_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      int k;
      k = int'(r_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (i_req[k[IDX_W-1:0]]) o_idx = k[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_grant) begin
      r_ptr <= (int'(o_idx) == N_REQ-1) ? '0 : o_idx + 1'b1;
    end
  end
`else
  always_comb begin
    o_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

  logic w_unused;
  assign w_unused = ^{clk, rst, i_grant};
`endif

endmodule

// File: rtl/lcd_msg_scheduler.sv
// rtl/lcd_msg_scheduler.sv - arbitrates whole-line LCD messages and streams address + 16 chars,
// skipping lines whose shadow already matches; LCD_SCHED_RR_EN enables round-robin arbitration
module lcd_msg_scheduler
  import lcd_msg_scheduler_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                 clk_1mhz,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ-1:0]     i_req_line,
  input  logic [N_REQ*128-1:0] i_req_text,
  output logic [N_REQ-1:0]     o_grant,
  output logic [N_REQ-1:0]     o_done,
  output logic                 o_busy,
  lcd_msg_scheduler_if.master  bus
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t           r_state;
  logic [3:0]       r_idx;
  logic [IDX_W-1:0] r_win;
  logic             r_line;
  logic [127:0]     r_text;
  logic [127:0]     r_shadow [2];
  logic [1:0]       r_shadow_vld;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_wr_valid;
  logic             r_wr_rs;
  logic [7:0]       r_wr_byte;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [3:0]       w_idx_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [N_REQ-1:0] w_done_nxt;
  logic             w_wr_valid_nxt;
  logic             w_wr_rs_nxt;
  logic [7:0]       w_wr_byte_nxt;
  logic             w_latch;
  logic             w_shadow_wr;
  logic             w_xfer;
  logic             w_dup;
  logic             w_arb_valid;
  logic [IDX_W-1:0] w_arb_idx;

  lcd_req_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk_1mhz),
    .rst     (rst),
    .i_req   (i_req),
    .i_grant (w_latch),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  assign w_xfer = r_wr_valid && bus.wr_ready;
  assign w_dup  = r_shadow_vld[r_line] && (r_shadow[r_line] == r_text);

  // Outputs are computed for the next state here and registered below
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_grant_nxt    = '0;
    w_done_nxt     = '0;
    w_wr_valid_nxt = 1'b0;
    w_wr_rs_nxt    = r_wr_rs;
    w_wr_byte_nxt  = r_wr_byte;
    w_latch        = 1'b0;
    w_shadow_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.init_done && w_arb_valid) begin
          w_state_nxt = S_GRANT;
          w_latch     = 1'b1;
          w_grant_nxt = ONE_HOT0 << w_arb_idx;
        end
      end
      S_GRANT: begin
        if (w_dup) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = ONE_HOT0 << r_win;
        end else begin
          w_state_nxt    = S_ADDR;
          w_wr_valid_nxt = 1'b1;
          w_wr_rs_nxt    = 1'b0;
          w_wr_byte_nxt  = lcd_line_cmd(r_line);
        end
      end
      S_ADDR: begin
        w_wr_valid_nxt = 1'b1;
        if (w_xfer) begin
          w_state_nxt   = S_CHAR;
          w_idx_nxt     = '0;
          w_wr_rs_nxt   = 1'b1;
          w_wr_byte_nxt = lcd_char_at(r_text, 4'd0);
        end
      end
      S_CHAR: begin
        w_wr_valid_nxt = 1'b1;
        if (w_xfer) begin
          if (r_idx == 4'(LCD_CHARS-1)) begin
            w_state_nxt    = S_DONE;
            w_wr_valid_nxt = 1'b0;
            w_shadow_wr    = 1'b1;
            w_done_nxt     = ONE_HOT0 << r_win;
          end else begin
            w_idx_nxt     = r_idx + 4'd1;
            w_wr_byte_nxt = lcd_char_at(r_text, r_idx + 4'd1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_win        <= '0;
      r_line       <= 1'b0;
      r_text       <= '0;
      r_shadow[0]  <= '0;
      r_shadow[1]  <= '0;
      r_shadow_vld <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_wr_valid   <= 1'b0;
      r_wr_rs      <= 1'b0;
      r_wr_byte    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_rs    <= w_wr_rs_nxt;
      r_wr_byte  <= w_wr_byte_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_latch) begin
        r_win  <= w_arb_idx;
        r_line <= i_req_line[w_arb_idx];
        r_text <= i_req_text[int'(w_arb_idx)*128 +: 128];
      end
      if (w_shadow_wr) begin
        r_shadow[r_line]     <= r_text;
        r_shadow_vld[r_line] <= 1'b1;
      end
    end
  end

  assign o_grant      = r_grant;
  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_rs    = r_wr_rs;
  assign bus.wr_byte  = r_wr_byte;

endmodule
